regfile_wr_ctrl: RTL and testbench

REGFILE_WR_CTRL -- requirements
Module: regfile_wr_ctrl

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/wr_fifo.sv | 66 ++++++
 rtl/regfile_wr_ctrl.sv | 171 +++++++++++++++++
 tb/tb_regfile_wr_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes, state encoding and request type for the register-file write controller.
package regfile_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 3;
    localparam int NREG       = 8;
    localparam int WBUF_DEPTH = 4;

    // Width of the buffered-entry count; must hold 0..WBUF_DEPTH inclusive.
    localparam int CNT_W      = $clog2(WBUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic [NREG-1:0] addr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NREG-1:0] sel;
        sel       = '0;
        sel[addr] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// Synchronous in-order FIFO with a flush that empties it in one edge.
// Flush wins over push and pop; push when full and pop when empty are ignored.
module wr_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    // Storage is data path only; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; explicit wrap so non-power-of-two depths work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Register-file write controller: accepted writes are buffered in order and
// committed one per cycle into eight registers; a clear request discards the
// buffer and zeroes the registers in an ascending one-per-cycle sweep.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | write buffer empty; waiting for a request or a clear
//   DRAIN | buffer non-empty; head commits on every edge with HOLD_i low
//   CLEAR | zeroing registers 0..7 one per cycle; requests are refused
module regfile_wr_ctrl
    import regfile_pkg::*;
(
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              WR_VALID_i,
    input  logic [ADDR_W-1:0] WR_ADDR_i,
    input  logic [DATA_W-1:0] WR_DATA_i,
    output logic              WR_READY_o,
    input  logic              HOLD_i,
    input  logic              CLR_i,
    output logic [DATA_W-1:0] REG_DATA0_o,
    output logic [DATA_W-1:0] REG_DATA1_o,
    output logic [DATA_W-1:0] REG_DATA2_o,
    output logic [DATA_W-1:0] REG_DATA3_o,
    output logic [DATA_W-1:0] REG_DATA4_o,
    output logic [DATA_W-1:0] REG_DATA5_o,
    output logic [DATA_W-1:0] REG_DATA6_o,
    output logic [DATA_W-1:0] REG_DATA7_o,
    output logic [NREG-1:0]   COMMIT_EN_o,
    output logic [CNT_W-1:0]  PENDING_o,
    output logic              BUSY_o
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_next;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   commit_en;

    wr_req_t           push_req;
    wr_req_t           fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              fifo_flush;
    logic              accept;

    logic              reg_we;
    logic [ADDR_W-1:0] reg_sel;
    logic [DATA_W-1:0] reg_wdata;

    // Ready is combinational on RST_i and CLR_i so that a clearing cycle or a
    // reset never accepts a request; a full buffer refuses even if it pops.
    assign WR_READY_o = ~fifo_full & (state != CLEAR) & ~RST_i & ~CLR_i;
    assign accept     = WR_VALID_i & WR_READY_o;
    assign push_req   = '{addr: WR_ADDR_i, data: WR_DATA_i};

    wr_fifo #(
        .WIDTH ($bits(wr_req_t)),
        .DEPTH (WBUF_DEPTH)
    ) u_wr_fifo (
        .clk       (CLK_i),
        .rst       (RST_i),
        .push      (accept),
        .push_data (push_req),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register and clear-sweep index.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= next_state;
            clr_idx <= clr_idx_next;
        end
    end

    // Next state, buffer control and the single register write port.
    always_comb begin
        next_state   = state;
        clr_idx_next = clr_idx;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        reg_we       = 1'b0;
        reg_sel      = '0;
        reg_wdata    = '0;

        unique case (state)
            IDLE: begin
                if (CLR_i) begin
                    fifo_flush   = 1'b1;
                    clr_idx_next = '0;
                    next_state   = CLEAR;
                end else if (accept) begin
                    next_state = DRAIN;
                end
            end

            DRAIN: begin
                if (CLR_i) begin
                    fifo_flush   = 1'b1;
                    clr_idx_next = '0;
                    next_state   = CLEAR;
                end else begin
                    if (!HOLD_i && !fifo_empty) begin
                        fifo_pop  = 1'b1;
                        reg_we    = 1'b1;
                        reg_sel   = fifo_head.addr;
                        reg_wdata = fifo_head.data;
                    end
                    if (fifo_pop && (fifo_count == CNT_W'(1)) && !accept) begin
                        next_state = IDLE;
                    end
                end
            end

            CLEAR: begin
                reg_we       = 1'b1;
                reg_sel      = clr_idx;
                reg_wdata    = '0;
                clr_idx_next = clr_idx + ADDR_W'(1);
                if (clr_idx == ADDR_W'(NREG - 1)) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Register array and the one-cycle commit strobe for whichever entry was written.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            commit_en <= '0;
        end else begin
            commit_en <= reg_we ? addr_onehot(reg_sel) : '0;
            if (reg_we) begin
                regs[reg_sel] <= reg_wdata;
            end
        end
    end

    assign REG_DATA0_o = regs[0];
    assign REG_DATA1_o = regs[1];
    assign REG_DATA2_o = regs[2];
    assign REG_DATA3_o = regs[3];
    assign REG_DATA4_o = regs[4];
    assign REG_DATA5_o = regs[5];
    assign REG_DATA6_o = regs[6];
    assign REG_DATA7_o = regs[7];

    assign COMMIT_EN_o = commit_en;
    assign PENDING_o   = fifo_count;
    assign BUSY_o      = (state == CLEAR);

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Self-checking bench for regfile_wr_ctrl: directed scenarios plus random
// traffic, all compared against a queue-and-array reference model.
module tb_regfile_wr_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       hold;
    logic       clr;
    logic [7:0] reg_data [8];
    logic [7:0] commit_en;
    logic [2:0] pending;
    logic       busy;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
    } req_t;

    // Reference model: pending writes as a queue, register contents as an array,
    // and a sweep position while a clear is in progress.
    req_t       mq[$];
    logic [7:0] mregs [8];
    logic [7:0] exp_commit;
    logic       exp_ready;
    logic       seen_ready;
    logic       m_clearing;
    int         m_sweep;

    int total;
    int bad;

    regfile_wr_ctrl dut (
        .CLK_i       (clk),
        .RST_i       (rst),
        .WR_VALID_i  (wr_valid),
        .WR_ADDR_i   (wr_addr),
        .WR_DATA_i   (wr_data),
        .WR_READY_o  (wr_ready),
        .HOLD_i      (hold),
        .CLR_i       (clr),
        .REG_DATA0_o (reg_data[0]),
        .REG_DATA1_o (reg_data[1]),
        .REG_DATA2_o (reg_data[2]),
        .REG_DATA3_o (reg_data[3]),
        .REG_DATA4_o (reg_data[4]),
        .REG_DATA5_o (reg_data[5]),
        .REG_DATA6_o (reg_data[6]),
        .REG_DATA7_o (reg_data[7]),
        .COMMIT_EN_o (commit_en),
        .PENDING_o   (pending),
        .BUSY_o      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        exp_commit = 8'h00;
        m_clearing = 1'b0;
        m_sweep    = 0;
    endtask

    // Drives one cycle (called 1 unit after a rising edge), records the ready
    // seen before the edge, advances the model across the edge, returns 1 unit
    // after it.
    task automatic drive_cycle(input logic v, input logic [2:0] a, input logic [7:0] d,
                               input logic h, input logic c);
        req_t r;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        hold     = h;
        clr      = c;
        #1;
        seen_ready = wr_ready;
        exp_ready  = !rst && (mq.size() < 4) && !m_clearing && !c;
        @(posedge clk);
        exp_commit = 8'h00;
        if (m_clearing) begin
            mregs[m_sweep]      = 8'h00;
            exp_commit[m_sweep] = 1'b1;
            m_sweep++;
            if (m_sweep == 8) m_clearing = 1'b0;
        end else if (c) begin
            mq.delete();
            m_clearing = 1'b1;
            m_sweep    = 0;
        end else begin
            if (mq.size() > 0 && !h) begin
                r = mq.pop_front();
                mregs[r.addr]      = r.data;
                exp_commit[r.addr] = 1'b1;
            end
            if (v && exp_ready) begin
                r.addr = a;
                r.data = d;
                mq.push_back(r);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        wr_valid = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 8'h3C;
        hold     = 1'b0;
        clr      = 1'b0;
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", wr_ready); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL reset_pending: got %0d expected 0", pending); end
        total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL reset_commit: got %h expected 00", commit_en); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== 8'h00) begin bad++; $display("FAIL reset_reg%0d: got %h expected 00", i, reg_data[i]); end
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_valid = 1'b0;
        #1;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b expected 1", wr_ready); end
    endtask

    task automatic test_single_write();
        drive_cycle(1'b1, 3'd3, 8'hA5, 1'b0, 1'b0);
        total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b expected 1", seen_ready); end
        total++; if (pending !== 3'd1) begin bad++; $display("FAIL single_pending: got %0d expected 1", pending); end
        total++; if (reg_data[3] !== 8'h00) begin bad++; $display("FAIL single_early: got %h expected 00", reg_data[3]); end
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        total++; if (reg_data[3] !== 8'hA5) begin bad++; $display("FAIL single_reg3: got %h expected a5", reg_data[3]); end
        total++; if (commit_en !== 8'b0000_1000) begin bad++; $display("FAIL single_commit: got %b expected 00001000", commit_en); end
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL single_commit_off: got %b expected 00000000", commit_en); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL single_drained: got %0d expected 0", pending); end
    endtask

    task automatic test_hold_full();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 3'(i), 8'(8'h40 + i), 1'b1, 1'b0);
            total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL hold_ready%0d: got %b expected %b", i, seen_ready, exp_ready); end
            total++; if (pending !== 3'(mq.size())) begin bad++; $display("FAIL hold_pending%0d: got %0d expected %0d", i, pending, mq.size()); end
            total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL hold_commit%0d: got %h expected 00", i, commit_en); end
        end
        total++; if (pending !== 3'd4) begin bad++; $display("FAIL hold_full_count: got %0d expected 4", pending); end
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== mregs[i]) begin bad++; $display("FAIL hold_reg%0d: got %h expected %h", i, reg_data[i], mregs[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(i == 0, 3'd7, 8'hEE, 1'b0, 1'b0);
            if (i == 0) begin
                total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL full_no_passthru: got %b expected 0", seen_ready); end
            end
            total++; if (commit_en !== ((i < 4) ? (8'h01 << i) : 8'h00)) begin bad++; $display("FAIL drain_commit%0d: got %b expected %b", i, commit_en, (i < 4) ? (8'h01 << i) : 8'h00); end
            total++; if (pending !== 3'(mq.size())) begin bad++; $display("FAIL drain_pending%0d: got %0d expected %0d", i, pending, mq.size()); end
        end
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== mregs[i]) begin bad++; $display("FAIL drain_reg%0d: got %h expected %h", i, reg_data[i], mregs[i]); end
        end
    endtask

    task automatic test_same_addr();
        int pulses;
        pulses = 0;
        drive_cycle(1'b1, 3'd2, 8'h11, 1'b0, 1'b0);
        if (commit_en[2]) pulses++;
        drive_cycle(1'b1, 3'd2, 8'h22, 1'b0, 1'b0);
        if (commit_en[2]) pulses++;
        total++; if (reg_data[2] !== 8'h11) begin bad++; $display("FAIL same_first: got %h expected 11", reg_data[2]); end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            if (commit_en[2]) pulses++;
        end
        total++; if (reg_data[2] !== 8'h22) begin bad++; $display("FAIL same_last: got %h expected 22", reg_data[2]); end
        total++; if (pulses != 2) begin bad++; $display("FAIL same_pulses: got %0d expected 2", pulses); end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 3'(i), 8'hFF, 1'b0, 1'b0);
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== 8'hFF) begin bad++; $display("FAIL clr_prefill%0d: got %h expected ff", i, reg_data[i]); end
        end
        drive_cycle(1'b1, 3'd1, 8'h5A, 1'b1, 1'b0);
        drive_cycle(1'b1, 3'd6, 8'h5B, 1'b1, 1'b0);
        total++; if (pending !== 3'd2) begin bad++; $display("FAIL clr_pending_before: got %0d expected 2", pending); end
        drive_cycle(1'b1, 3'd4, 8'h5C, 1'b0, 1'b1);
        total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b expected 0", seen_ready); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL clr_flush: got %0d expected 0", pending); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy_start: got %b expected 1", busy); end
        total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL clr_no_commit: got %h expected 00", commit_en); end
        for (int k = 0; k < 8; k++) begin
            drive_cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)), k == 3);
            total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL sweep_ready%0d: got %b expected 0", k, seen_ready); end
            total++; if (commit_en !== (8'h01 << k)) begin bad++; $display("FAIL sweep_commit%0d: got %b expected %b", k, commit_en, 8'h01 << k); end
            total++; if (busy !== (k < 7)) begin bad++; $display("FAIL sweep_busy%0d: got %b expected %b", k, busy, k < 7); end
            for (int i = 0; i < 8; i++) begin
                total++; if (reg_data[i] !== mregs[i]) begin bad++; $display("FAIL sweep_reg%0d_%0d: got %h expected %h", k, i, reg_data[i], mregs[i]); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL post_clr_ready%0d: got %b expected 1", k, seen_ready); end
            total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL post_clr_commit%0d: got %h expected 00", k, commit_en); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_clr_busy%0d: got %b expected 0", k, busy); end
        end
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== 8'h00) begin bad++; $display("FAIL post_clr_reg%0d: got %h expected 00", i, reg_data[i]); end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 3'(i), 8'(8'hC0 + i), 1'b0, 1'b0);
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midclr_busy: got %b expected 1", busy); end
        total++; if (reg_data[3] !== 8'hC3) begin bad++; $display("FAIL midclr_reg3: got %h expected c3", reg_data[3]); end
        total++; if (reg_data[2] !== 8'h00) begin bad++; $display("FAIL midclr_reg2: got %h expected 00", reg_data[2]); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL midclr_rst_ready: got %b expected 0", wr_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclr_rst_busy: got %b expected 0", busy); end
        total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL midclr_rst_commit: got %h expected 00", commit_en); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL midclr_rst_pending: got %0d expected 0", pending); end
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== 8'h00) begin bad++; $display("FAIL midclr_rst_reg%0d: got %h expected 00", i, reg_data[i]); end
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL midclr_release_ready: got %b expected 1", wr_ready); end
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
            total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL midclr_after_commit%0d: got %h expected 00", k, commit_en); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL midclr_after_busy%0d: got %b expected 0", k, busy); end
        end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 3'(i + 4), 8'(8'h90 + i), 1'b1, 1'b0);
        drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        total++; if (reg_data[4] !== 8'h90) begin bad++; $display("FAIL middrain_first: got %h expected 90", reg_data[4]); end
        total++; if (pending !== 3'd2) begin bad++; $display("FAIL middrain_pending: got %0d expected 2", pending); end
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
            total++; if (pending !== 3'd0) begin bad++; $display("FAIL middrain_after_pending%0d: got %0d expected 0", k, pending); end
            total++; if (commit_en !== 8'h00) begin bad++; $display("FAIL middrain_after_commit%0d: got %h expected 00", k, commit_en); end
        end
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== mregs[i]) begin bad++; $display("FAIL middrain_reg%0d: got %h expected %h", i, reg_data[i], mregs[i]); end
        end
    endtask

    task automatic test_stream();
        int maxp;
        maxp = 0;
        for (int k = 0; k < 16; k++) begin
            drive_cycle(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b0);
            if (int'(pending) > maxp) maxp = int'(pending);
            total++; if (seen_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d: got %b expected 1", k, seen_ready); end
            total++; if (commit_en !== exp_commit) begin bad++; $display("FAIL stream_commit%0d: got %b expected %b", k, commit_en, exp_commit); end
        end
        for (int k = 0; k < 2; k++) drive_cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        total++; if (maxp > 1) begin bad++; $display("FAIL stream_max_pending: got %0d expected <=1", maxp); end
        for (int i = 0; i < 8; i++) begin
            total++; if (reg_data[i] !== mregs[i]) begin bad++; $display("FAIL stream_reg%0d: got %h expected %h", i, reg_data[i], mregs[i]); end
        end
    endtask

    task automatic test_random_mix();
        logic v, h, c;
        logic [2:0] a;
        logic [7:0] d;
        for (int k = 0; k < 120; k++) begin
            v = ($urandom_range(0, 3) != 0);
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            h = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 24) == 0);
            drive_cycle(v, a, d, h, c);
            total++; if (seen_ready !== exp_ready) begin bad++; $display("FAIL mix_ready%0d: got %b expected %b", k, seen_ready, exp_ready); end
            total++; if (pending !== 3'(mq.size())) begin bad++; $display("FAIL mix_pending%0d: got %0d expected %0d", k, pending, mq.size()); end
            total++; if (commit_en !== exp_commit) begin bad++; $display("FAIL mix_commit%0d: got %b expected %b", k, commit_en, exp_commit); end
            total++; if (busy !== m_clearing) begin bad++; $display("FAIL mix_busy%0d: got %b expected %b", k, busy, m_clearing); end
            for (int i = 0; i < 8; i++) begin
                total++; if (reg_data[i] !== mregs[i]) begin bad++; $display("FAIL mix_reg%0d_%0d: got %h expected %h", k, i, reg_data[i], mregs[i]); end
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 8'h00;
        hold     = 1'b0;
        clr      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_hold_full();
        test_same_addr();
        test_clear();
        test_reset_mid_clear();
        test_reset_mid_drain();
        test_stream();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
